// File: rtl/aemb2_pkg.sv
// Shared decode constants, select encodings, injection FSM states and opcode helpers
// for the multithreaded instruction decode/mux stage.
package aemb2_pkg;

  localparam logic [5:0] OpcMul  = 6'o20;
  localparam logic [5:0] OpcMuli = 6'o30;
  localparam logic [5:0] OpcBsf  = 6'o21;
  localparam logic [5:0] OpcBsfi = 6'o31;
  localparam logic [5:0] OpcGet  = 6'o33;
  localparam logic [5:0] OpcSft  = 6'o44;
  localparam logic [5:0] OpcMov  = 6'o45;
  localparam logic [5:0] OpcBru  = 6'o46;
  localparam logic [5:0] OpcBcc  = 6'o47;
  localparam logic [5:0] OpcRtd  = 6'o55;
  localparam logic [5:0] OpcBrui = 6'o56;
  localparam logic [5:0] OpcBcci = 6'o57;
  localparam logic [4:0] RdRtid  = 5'h11;

  // ALU select encodings
  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluLog = 3'd1;
  localparam logic [2:0] AluSft = 3'd2;
  localparam logic [2:0] AluMov = 3'd3;
  localparam logic [2:0] AluMul = 3'd4;
  localparam logic [2:0] AluBsf = 3'd5;

  // Writeback operand select encodings
  localparam logic [2:0] OpdAlu = 3'd0;
  localparam logic [2:0] OpdLnk = 3'd1;
  localparam logic [2:0] OpdLod = 3'd2;
  localparam logic [2:0] OpdMul = 3'd3;
  localparam logic [2:0] OpdNop = 3'd7;

  localparam logic [31:0] NopVec    = 32'h8800_0000;
  localparam logic [31:0] IntVecDef = 32'hB9CE_0010;
  localparam logic [31:0] XceVecDef = 32'hBA2D_0020;

  typedef enum logic [1:0] {StIdle, StPend, StInj, StMask} inj_state_e;

  typedef struct packed {
    logic sft;
    logic lgc;
    logic mul;
    logic bsf;
    logic bru;
    logic bra;
    logic bcc;
    logic rtd;
    logic mov;
    logic lod;
    logic str;
    logic get;
    logic rtid;
  } dec_t;

  function automatic logic is_bru(input logic [5:0] opc);
    return (opc == OpcBru) || (opc == OpcBrui);
  endfunction

  function automatic logic is_mov(input logic [5:0] opc);
    return opc == OpcMov;
  endfunction

  function automatic logic is_str(input logic [5:0] opc);
    return {opc[5:4], opc[2]} == 3'o7;
  endfunction

  function automatic dec_t aemb2_decode(input logic [5:0] opc, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb,
                                        input logic mulEn, input logic bsfEn,
                                        input logic fslEn);
    dec_t d;
    d.sft  = (opc == OpcSft);
    d.lgc  = ({opc[5:4], opc[2]} == 3'o4);
    d.mul  = mulEn && ((opc == OpcMul) || (opc == OpcMuli));
    d.bsf  = bsfEn && ((opc == OpcBsf) || (opc == OpcBsfi));
    d.bru  = is_bru(opc);
    d.bra  = d.bru && ra[3];
    d.bcc  = (opc == OpcBcc) || (opc == OpcBcci);
    d.rtd  = (opc == OpcRtd);
    d.mov  = is_mov(opc);
    d.lod  = ({opc[5:4], opc[2]} == 3'o6);
    d.str  = is_str(opc);
    d.get  = fslEn && (opc == OpcGet) && !rb[4];
    d.rtid = d.rtd && (rd == RdRtid);
    return d;
  endfunction

endpackage

// File: rtl/aemb2_hzd_trk.sv
// Thread-tagged shift pipeline of post-decode writeback (opd, rd) with load/mul
// hazard comparators against the instruction currently in IF.
module aemb2_hzd_trk
  import aemb2_pkg::*;
#(
  parameter int unsigned TW        = 1,
  parameter int unsigned HZD_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ena_i,
  input  logic [TW-1:0] tidIf_i,
  input  logic [4:0]    raIf_i,
  input  logic [4:0]    rbIf_i,
  input  logic [4:0]    rdIf_i,
  input  logic          useRa_i,
  input  logic          useRb_i,
  input  logic          useRd_i,
  input  logic [TW-1:0] tidIn_i,
  input  logic [2:0]    opdIn_i,
  input  logic [4:0]    rdIn_i,
  output logic          hzd_o,
  output logic [2:0]    opdEx_o,
  output logic [4:0]    rdEx_o,
  output logic [2:0]    opdMa_o,
  output logic [4:0]    rdMa_o
);

  logic [TW-1:0] stgTid_q [HZD_DEPTH];
  logic [2:0]    stgOpd_q [HZD_DEPTH];
  logic [4:0]    stgRd_q  [HZD_DEPTH];
  logic [2:0]    opdEx_q, opdMa_q;
  logic [4:0]    rdEx_q, rdMa_q;
  logic          hzd;

  // Shift the tracked stages; EX/MA outputs are separate copies so they reset to 0
  // while the internal stages reset to "no writeback".
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < int'(HZD_DEPTH); k++) begin
        stgTid_q[k] <= '0;
        stgOpd_q[k] <= OpdNop;
        stgRd_q[k]  <= '0;
      end
      opdEx_q <= '0;
      rdEx_q  <= '0;
      opdMa_q <= '0;
      rdMa_q  <= '0;
    end else if (ena_i) begin
      stgTid_q[0] <= tidIn_i;
      stgOpd_q[0] <= opdIn_i;
      stgRd_q[0]  <= rdIn_i;
      for (int k = 1; k < int'(HZD_DEPTH); k++) begin
        stgTid_q[k] <= stgTid_q[k-1];
        stgOpd_q[k] <= stgOpd_q[k-1];
        stgRd_q[k]  <= stgRd_q[k-1];
      end
      opdEx_q <= opdIn_i;
      rdEx_q  <= rdIn_i;
      opdMa_q <= stgOpd_q[0];
      rdMa_q  <= stgRd_q[0];
    end
  end

  // Flag a hazard when a same-thread load/mul result is still in flight
  always_comb begin
    hzd = 1'b0;
    for (int k = 0; k < int'(HZD_DEPTH); k++) begin
      if ((stgTid_q[k] == tidIf_i) && ((stgOpd_q[k] == OpdLod) || (stgOpd_q[k] == OpdMul)) &&
          (stgRd_q[k] != 5'd0) &&
          ((useRb_i && (rbIf_i == stgRd_q[k])) || (useRa_i && (raIf_i == stgRd_q[k])) ||
           (useRd_i && (rdIf_i == stgRd_q[k])))) begin
        hzd = 1'b1;
      end
    end
  end

  assign hzd_o   = hzd;
  assign opdEx_o = opdEx_q;
  assign rdEx_o  = rdEx_q;
  assign opdMa_o = opdMa_q;
  assign rdMa_o  = rdMa_q;

endmodule

// File: rtl/aemb2_idmx_mt.sv
// Multithreaded decode/mux stage: decodes the fetched instruction, inserts NOPs on
// branch/hazard/off-phase slots and injects interrupt/exception opcodes.
module aemb2_idmx_mt
  import aemb2_pkg::*;
#(
  parameter int unsigned  THREADS   = 2,
  parameter int unsigned  HZD_DEPTH = 2,
  parameter int unsigned  MUL       = 1,
  parameter int unsigned  BSF       = 1,
  parameter int unsigned  FSL       = 1,
  parameter logic [31:0]  INT_VEC   = IntVecDef,
  parameter logic [31:0]  XCE_VEC   = XceVecDef,
  localparam int unsigned TW        = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ena_i,
  input  logic [TW-1:0] rTID_IF,
  input  logic [1:0]    rBRA,
  input  logic          rXCE,
  input  logic          rINT,
  input  logic [5:0]    rOPC_IF,
  input  logic [4:0]    rRD_IF,
  input  logic [4:0]    rRA_IF,
  input  logic [4:0]    rRB_IF,
  input  logic [15:0]   rIMM_IF,
  output logic [5:0]    rOPC_OF,
  output logic [4:0]    rRD_OF,
  output logic [4:0]    rRA_OF,
  output logic [15:0]   rIMM_OF,
  output logic [2:0]    rALU_OF,
  output logic [TW-1:0] rTID_OF,
  output logic [4:0]    rRD_EX,
  output logic [4:0]    rRD_MA,
  output logic [2:0]    rOPD_EX,
  output logic [2:0]    rOPD_MA,
  output logic          rHZD_O,
  output logic [1:0]    rINJ_O
);

  logic [TW-1:0]      pha_q;
  inj_state_e         st_q [THREADS];
  logic [THREADS-1:0] xce_q, xce_d, injXVec, injIVec, rtidVec;
  logic               hzd, phaseMiss, skip, eligBase, injX, injI;
  logic [31:0]        insWord;
  logic [4:0]         insRb;
  logic [2:0]         aluSel, opdSel;
  dec_t               dec;

  assign phaseMiss = (THREADS > 1) && (rTID_IF != pha_q);
  assign skip      = (rBRA == 2'o2) || hzd || phaseMiss;
  assign eligBase  = (rBRA == 2'o0) && !hzd && !phaseMiss;

  aemb2_hzd_trk #(
    .TW       (TW),
    .HZD_DEPTH(HZD_DEPTH)
  ) u_hzd_trk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .ena_i  (ena_i),
    .tidIf_i(rTID_IF),
    .raIf_i (rRA_IF),
    .rbIf_i (rRB_IF),
    .rdIf_i (rRD_IF),
    .useRa_i(!is_bru(rOPC_IF)),
    .useRb_i(!(is_mov(rOPC_IF) || rOPC_IF[3])),
    .useRd_i(is_str(rOPC_IF)),
    .tidIn_i(rTID_IF),
    .opdIn_i(opdSel),
    .rdIn_i (insWord[25:21]),
    .hzd_o  (hzd),
    .opdEx_o(rOPD_EX),
    .rdEx_o (rRD_EX),
    .opdMa_o(rOPD_MA),
    .rdMa_o (rRD_MA)
  );

  // Per-thread injection arbitration; an exception pulse counts in its own cycle
  always_comb begin
    injXVec = '0;
    injIVec = '0;
    xce_d   = xce_q;
    for (int t = 0; t < int'(THREADS); t++) begin
      injXVec[t] = eligBase && (rTID_IF == TW'(t)) &&
                   (xce_q[t] || (rXCE && (rTID_IF == TW'(t))));
      injIVec[t] = eligBase && (rTID_IF == TW'(t)) && (t == 0) && rINT &&
                   (st_q[t] == StPend) && !injXVec[t];
      xce_d[t]   = (xce_q[t] || (rXCE && (rTID_IF == TW'(t)))) && !injXVec[t];
    end
  end

  assign injX = |injXVec;
  assign injI = |injIVec;

  // Select the instruction word that goes down the pipe this cycle
  always_comb begin
    insWord = {rOPC_IF, rRD_IF, rRA_IF, rIMM_IF};
    insRb   = rRB_IF;
    if (skip) begin
      insWord = NopVec;
      insRb   = NopVec[15:11];
    end else if (injX) begin
      insWord = XCE_VEC;
      insRb   = XCE_VEC[15:11];
    end else if (injI) begin
      insWord = INT_VEC;
      insRb   = INT_VEC[15:11];
    end
  end

  assign dec = aemb2_decode(insWord[31:26], insWord[25:21], insWord[20:16], insRb,
                            MUL != 0, BSF != 0, FSL != 0);

  // ALU and writeback select priority encoders
  always_comb begin
    aluSel = AluAdd;
    if (skip)                  aluSel = AluLog;
    else if (dec.bra || dec.mov) aluSel = AluMov;
    else if (dec.sft)          aluSel = AluSft;
    else if (dec.lgc)          aluSel = AluLog;
    else if (dec.mul)          aluSel = AluMul;
    else if (dec.bsf)          aluSel = AluBsf;

    opdSel = OpdNop;
    if (skip)                                 opdSel = OpdNop;
    else if (dec.str || dec.rtd || dec.bcc)   opdSel = OpdNop;
    else if (dec.lod || dec.get)              opdSel = OpdLod;
    else if (dec.bru)                         opdSel = OpdLnk;
    else if (dec.mul)                         opdSel = OpdMul;
    else if (insWord[25:21] != 5'd0)          opdSel = OpdAlu;
  end

  // RTID retires the interrupt mask only when it is actually decoded for that thread
  always_comb begin
    rtidVec = '0;
    for (int t = 0; t < int'(THREADS); t++) begin
      rtidVec[t] = !skip && !injX && !injI && dec.rtid && (rTID_IF == TW'(t));
    end
  end

  // Thread phase, pending exceptions and per-thread interrupt FSMs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pha_q <= '0;
      xce_q <= '0;
      for (int t = 0; t < int'(THREADS); t++) st_q[t] <= StIdle;
    end else if (ena_i) begin
      pha_q <= (THREADS > 1) ? pha_q + 1'b1 : '0;
      xce_q <= xce_d;
      for (int t = 0; t < int'(THREADS); t++) begin
        case (st_q[t])
          StIdle:  if ((t == 0) && rINT) st_q[t] <= StPend;
          StPend: begin
            if (!((t == 0) && rINT)) st_q[t] <= StIdle;
            else if (injIVec[t])     st_q[t] <= StInj;
          end
          StInj:   st_q[t] <= StMask;
          StMask:  if (rtidVec[t]) st_q[t] <= StIdle;
          default: st_q[t] <= StIdle;
        endcase
      end
    end
  end

  // Registered decode outputs to the OF stage
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rOPC_OF <= '0;
      rRD_OF  <= '0;
      rRA_OF  <= '0;
      rIMM_OF <= '0;
      rALU_OF <= '0;
      rTID_OF <= '0;
      rHZD_O  <= 1'b0;
      rINJ_O  <= 2'd0;
    end else if (ena_i) begin
      rOPC_OF <= insWord[31:26];
      rRD_OF  <= insWord[25:21];
      rRA_OF  <= insWord[20:16];
      rIMM_OF <= insWord[15:0];
      rALU_OF <= aluSel;
      rTID_OF <= rTID_IF;
      rHZD_O  <= hzd;
      rINJ_O  <= injX ? 2'd2 : (injI ? 2'd1 : 2'd0);
    end
  end

endmodule

// File: doc/aemb2_idmx_mt.md
AEMB2_IDMX_MT -- requirements
Module: aemb2_idmx_mt

Interface
REQ-001 THREADS, default 2, hardware thread count; legal values 1, 2, 4; TW = max(1, log2(THREADS)).
REQ-002 HZD_DEPTH, default 2, number of post-decode stages tracked for load/mul hazards; legal range 2..4.
REQ-003 MUL, default 1, multiplier present; BSF, default 1, barrel shifter present; FSL, default 1, FSL get/put present.
REQ-004 INT_VEC, default 32'hB9CE0010, injected interrupt opcode; XCE_VEC, default 32'hBA2D0020, injected exception opcode.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-low.
REQ-007 ena_i  in  1  pipeline advance enable; when low, all state holds.
REQ-008 rTID_IF  in  TW  thread id of the instruction in IF.
REQ-009 rBRA  in  2  branch status; 2'o2 means non-delay branch taken; nonzero means delay slot.
REQ-010 rXCE, rINT  in  1 each  exception pulse; interrupt request (level).
REQ-011 rOPC_IF 6, rRD_IF/rRA_IF/rRB_IF 5 each, rIMM_IF 16  in  fetched instruction fields.
REQ-012 rOPC_OF 6, rRD_OF 5, rRA_OF 5, rIMM_OF 16, rALU_OF 3, rTID_OF TW  out  decoded fields to OF stage.
REQ-013 rRD_EX, rRD_MA 5; rOPD_EX, rOPD_MA 3  out  writeback destination and select of EX and MA stages.
REQ-014 rHZD_O 1, rINJ_O 2  out  stall-inserted flag; injection marker (0 none, 1 interrupt, 2 exception).

Function
REQ-015 Decode classes SHALL be: SFT 6'o44; LOG {opc[5:4],opc[2]}=3'o4; MUL 6'o20/6'o30 (MUL=1 only); BSF 6'o21/6'o31 (BSF=1 only); BRU 6'o46/6'o56; BRA = BRU & ra[3]; BCC 6'o47/6'o57; RTD 6'o55; MOV 6'o45; LOD {opc[5:4],opc[2]}=3'o6; STR 3'o7; GET 6'o33 & !rb[4] (FSL=1 only); RTID = RTD & rd=5'h11.
REQ-016 rALU_OF priority: skip->1, BRA|MOV->3, SFT->2, LOG->1, MUL->4, BSF->5, else 0; one-cycle latency.
REQ-017 rOPD select priority: skip->7, STR|RTD|BCC->7, LOD|GET->2, BRU->1, MUL->3, rd!=0->0, else 7.
REQ-018 rOPD and rRD SHALL flow through a HZD_DEPTH-stage shift pipeline tagged with thread id; rOPD_EX/rRD_EX = stage 1, rOPD_MA/rRD_MA = stage 2.
REQ-019 Hazard SHALL be flagged when any tracked stage with same thread id, opd in {2,3}, rd!=0 matches: rb (unless MOV or opc[3]), ra (unless BRU), or rd when STR.
REQ-020 Skip = (rBRA==2'o2) | hazard | (THREADS>1 and rTID_IF not the scheduled phase thread); skip replaces outputs with NOP 32'h88000000 and sets rHZD_O=1 only on hazard.
REQ-021 Injection FSM states IDLE, PEND, INJ, MASK (one per thread, interrupt routed to thread 0).
REQ-022 IDLE->PEND on rINT=1; PEND->INJ on first cycle with rBRA==0, no hazard, rTID_IF==0; INJ emits INT_VEC fields, rINJ_O=1, ->MASK next cycle; MASK->IDLE when RTID decoded for thread 0.
REQ-023 rXCE pulse SHALL latch a pending exception for rTID_IF, injected at the next eligible slot (same rules as REQ-022) with XCE_VEC and rINJ_O=2, regardless of FSM state.
REQ-024 Exception and interrupt eligible in same cycle: exception wins; interrupt stays PEND.
REQ-025 Replaced fetched instruction is not consumed; fetch is expected to replay it (outside scope).
REQ-026 rINT dropping while PEND SHALL return FSM to IDLE; while INJ/MASK it has no effect.

Reset
REQ-027 On rst_i=0, asynchronously: all outputs 0, all tracked stages opd=7 rd=0, FSMs IDLE, pending exceptions cleared; de-assertion takes effect next clk_i edge.

Structure
REQ-028 Shared package aemb2_pkg SHALL hold opcode constants, ALU/OPD select encodings, FSM state enum, NOP/INT/XCE opcode defaults.
REQ-029 One sub-module aemb2_hzd_trk (tracked-stage shift pipeline plus comparators), instantiated once.

Verification
REQ-030 LW r3 then ADD r4,r3,r5 same thread -> second slot NOP, rHZD_O=1, rALU_OF=1, rOPD_EX=7 next cycle.
REQ-031 LW r3 thread 0 then ADD r4,r3,r5 thread 1 (THREADS=2) -> no hazard, ADD passes, rOPD_EX=0.
REQ-032 rINT=1 while rBRA=2'o1 -> no injection; next cycle rBRA=0 -> rOPC_OF/rIMM_OF from 32'hB9CE0010, rINJ_O=1.
REQ-033 rXCE and pending interrupt same eligible cycle -> 32'hBA2D0020 emitted, rINJ_O=2; interrupt injected next eligible slot.
REQ-034 In MASK, second rINT -> no injection until RTID (opc 6'o55, rd 5'h11) decoded.
REQ-035 rst_i low mid-PEND with HZD_DEPTH=4 -> all outputs 0 immediately, no injection after release.
